// File: rtl/game_mmio_ram.sv
// Data RAM with memory-mapped game inputs (press-latched buttons, frame counter) and
// renderer taps that are refreshed only once per frame so a frame never tears.
module game_mmio_ram #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 12,
   parameter int DEPTH         = 2048,
   parameter int NUM_SPRITES   = 10,
   parameter int SPRITE_BASE   = 1010,
   parameter int SPRITE_STRIDE = 10,
   parameter int LEFT_ADDR     = 400,
   parameter int RIGHT_ADDR    = 800,
   parameter int LASER_ADDR    = 1200,
   parameter int LIVES_ADDR    = 1250,
   parameter int SCORE_ADDR    = 1300,
   parameter int PLAYER_ADDR   = 2000,
   parameter int FRAME_ADDR    = 1400,
   parameter int FRAME_WIDTH   = 32
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wEn,
   input  logic [ADDRESS_WIDTH-1:0]    addr,
   input  logic [DATA_WIDTH-1:0]       dataIn,
   output logic [DATA_WIDTH-1:0]       dataOut,
   input  logic                        moveLeft,
   input  logic                        moveRight,
   input  logic                        laserOn,
   input  logic                        frameTick,
   output logic [NUM_SPRITES*32-1:0]   spriteX,
   output logic [NUM_SPRITES*32-1:0]   spriteY,
   output logic [31:0]                 playerX,
   output logic [31:0]                 playerY,
   output logic [31:0]                 playerLives,
   output logic [31:0]                 playerScore,
   output logic [31:0]                 laser
);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   function automatic logic is_io(input int x);
      return x == LEFT_ADDR || x == RIGHT_ADDR || x == LASER_ADDR || x == LIVES_ADDR ||
             x == SCORE_ADDR || x == FRAME_ADDR || x == PLAYER_ADDR || x == PLAYER_ADDR + 1;
   endfunction

   function automatic logic cfg_bad();
      logic bad;
      int   sx;
      bad = 1'b0;
      if (NUM_SPRITES < 1 || NUM_SPRITES > 64) bad = 1'b1;
      if (LEFT_ADDR >= DEPTH || RIGHT_ADDR >= DEPTH || LASER_ADDR >= DEPTH ||
          LIVES_ADDR >= DEPTH || SCORE_ADDR >= DEPTH || FRAME_ADDR >= DEPTH ||
          PLAYER_ADDR + 1 >= DEPTH) bad = 1'b1;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         sx = SPRITE_BASE + i * SPRITE_STRIDE;
         if (sx + 1 >= DEPTH || is_io(sx) || is_io(sx + 1)) bad = 1'b1;
      end
      return bad;
   endfunction

   localparam logic CFG_BAD = cfg_bad();
   if (CFG_BAD) begin : g_cfg_err
      $error("game_mmio_ram: address map out of range or sprite words overlap I/O words");
   end

   logic [DATA_WIDTH-1:0]     mem [DEPTH];
   logic [3:0]                async_in;
   logic [3:0]                sync1_q, sync2_q, prev_q;
   logic [3:0]                rise;
   logic [2:0]                sticky_q, sticky_d;
   logic [FRAME_WIDTH-1:0]    frame_q;
   logic [DATA_WIDTH-1:0]     dout_q, rdata;
   logic [NUM_SPRITES*32-1:0] sprite_x_q, sprite_y_q;
   logic [31:0]               player_x_q, player_y_q, lives_q, score_q, laser_q;
   logic [31:0]               addr_w;
   logic [IDX_W-1:0]          idx;
   logic                      mapped, read_only, frame_rise;

   // Bit order {frame, laser, right, left} shared by all synchroniser vectors.
   assign async_in   = {frameTick, laserOn, moveRight, moveLeft};
   assign rise       = sync2_q & ~prev_q;
   assign frame_rise = rise[3];
   assign addr_w     = 32'(addr);
   assign idx        = addr[IDX_W-1:0];
   assign mapped     = addr_w < 32'(DEPTH);
   assign read_only  = addr_w == 32'(LEFT_ADDR) || addr_w == 32'(RIGHT_ADDR) ||
                       addr_w == 32'(LASER_ADDR) || addr_w == 32'(FRAME_ADDR);

   always_comb begin
      rdata = mem[idx];
      if (!mapped)
         rdata = '0;
      else if (addr_w == 32'(LEFT_ADDR))
         rdata = {{(DATA_WIDTH-2){1'b0}}, sticky_q[0], sync2_q[0]};
      else if (addr_w == 32'(RIGHT_ADDR))
         rdata = {{(DATA_WIDTH-2){1'b0}}, sticky_q[1], sync2_q[1]};
      else if (addr_w == 32'(LASER_ADDR))
         rdata = {{(DATA_WIDTH-2){1'b0}}, sticky_q[2], sync2_q[2]};
      else if (addr_w == 32'(FRAME_ADDR))
         rdata = DATA_WIDTH'(frame_q);
   end

   // A load clears its word's press latch, but a press landing the same cycle wins.
   always_comb begin
      sticky_d = sticky_q;
      if (!wEn) begin
         if (addr_w == 32'(LEFT_ADDR))  sticky_d[0] = 1'b0;
         if (addr_w == 32'(RIGHT_ADDR)) sticky_d[1] = 1'b0;
         if (addr_w == 32'(LASER_ADDR)) sticky_d[2] = 1'b0;
      end
      sticky_d = sticky_d | rise[2:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         sticky_q   <= '0;
         frame_q    <= '0;
         dout_q     <= '0;
         sprite_x_q <= '0;
         sprite_y_q <= '0;
         player_x_q <= '0;
         player_y_q <= '0;
         lives_q    <= '0;
         score_q    <= '0;
         laser_q    <= '0;
      end else begin
         sync1_q  <= async_in;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         sticky_q <= sticky_d;
         if (!wEn) dout_q <= rdata;
         if (frame_rise) begin
            frame_q <= frame_q + 1'b1;
            for (int i = 0; i < NUM_SPRITES; i++) begin
               sprite_x_q[32*i +: 32] <= 32'(mem[IDX_W'(SPRITE_BASE + i*SPRITE_STRIDE)]);
               sprite_y_q[32*i +: 32] <= 32'(mem[IDX_W'(SPRITE_BASE + i*SPRITE_STRIDE + 1)]);
            end
            player_x_q <= 32'(mem[IDX_W'(PLAYER_ADDR)]);
            player_y_q <= 32'(mem[IDX_W'(PLAYER_ADDR + 1)]);
            lives_q    <= 32'(mem[IDX_W'(LIVES_ADDR)]);
            score_q    <= 32'(mem[IDX_W'(SCORE_ADDR)]);
            laser_q    <= {31'b0, sync2_q[2]};
         end
      end
   end

   // Array contents survive reset; only configuration zeroes them.
   always_ff @(posedge clk) begin
      if (wEn && mapped && !read_only) mem[idx] <= dataIn;
   end

   assign dataOut     = dout_q;
   assign spriteX     = sprite_x_q;
   assign spriteY     = sprite_y_q;
   assign playerX     = player_x_q;
   assign playerY     = player_y_q;
   assign playerLives = lives_q;
   assign playerScore = score_q;
   assign laser       = laser_q;
endmodule

// File: tb/tb_game_mmio_ram.sv
// Bench for game_mmio_ram: per-cycle comparison against a behavioural model plus
// directed literal checks (reset, snapshot, clear-on-read, drops, frame wrap).
module tb_game_mmio_ram;
   localparam int NS = 10, DEPTH = 2048, FW = 4, TW = NS * 32;
   localparam int LEFT = 400, RIGHT = 800, LASER = 1200, LIVES = 1250, SCORE = 1300;
   localparam int PLAYER = 2000, FRAME = 1400, SB = 1010, SS = 10;
   localparam logic [31:0] FMASK = (32'd1 << FW) - 32'd1;

   logic clk = 1'b0, reset = 1'b1, wEn = 1'b0;
   logic [11:0] addr = '0;
   logic [31:0] dataIn = '0, dataOut;
   logic moveLeft = 1'b0, moveRight = 1'b0, laserOn = 1'b0, frameTick = 1'b0;
   logic [TW-1:0] spriteX, spriteY;
   logic [31:0] playerX, playerY, playerLives, playerScore, laser;

   int n_cmp = 0, n_err = 0;
   logic chk_en = 1'b0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   game_mmio_ram #(.FRAME_WIDTH(FW)) dut (
      .clk(clk), .reset(reset), .wEn(wEn), .addr(addr), .dataIn(dataIn), .dataOut(dataOut),
      .moveLeft(moveLeft), .moveRight(moveRight), .laserOn(laserOn), .frameTick(frameTick),
      .spriteX(spriteX), .spriteY(spriteY), .playerX(playerX), .playerY(playerY),
      .playerLives(playerLives), .playerScore(playerScore), .laser(laser)
   );

   // ---------------- behavioural model ----------------
   // hist1/2/3: button/tick vector {frame,laser,right,left} as sampled 1/2/3 edges ago.
   logic [31:0] m_mem [DEPTH];
   logic [3:0]  hist1 = '0, hist2 = '0, hist3 = '0;
   logic [2:0]  m_sticky = '0;
   logic [31:0] m_frame = '0, m_dout = '0;
   logic [TW-1:0] m_sx = '0, m_sy = '0;
   logic [31:0] m_px = '0, m_py = '0, m_lives = '0, m_score = '0, m_laser = '0;

   initial for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

   function automatic logic [31:0] m_word(input int a);
      if (a >= DEPTH) return 32'h0;
      if (a == LEFT)  return {30'b0, m_sticky[0], hist2[0]};
      if (a == RIGHT) return {30'b0, m_sticky[1], hist2[1]};
      if (a == LASER) return {30'b0, m_sticky[2], hist2[2]};
      if (a == FRAME) return m_frame;
      return m_mem[a];
   endfunction

   always @(posedge clk) begin
      int a;
      logic [3:0] pressed;
      a = int'(addr);
      if (reset) begin
         hist1 = '0; hist2 = '0; hist3 = '0; m_sticky = '0; m_frame = '0; m_dout = '0;
         m_sx = '0; m_sy = '0; m_px = '0; m_py = '0; m_lives = '0; m_score = '0; m_laser = '0;
      end else begin
         pressed = hist2 & ~hist3;
         if (!wEn) begin
            m_dout = m_word(a);
            if (a == LEFT)  m_sticky[0] = 1'b0;
            if (a == RIGHT) m_sticky[1] = 1'b0;
            if (a == LASER) m_sticky[2] = 1'b0;
         end
         m_sticky = m_sticky | pressed[2:0];
         if (pressed[3]) begin
            for (int i = 0; i < NS; i++) begin
               m_sx[32*i +: 32] = m_mem[SB + i*SS];
               m_sy[32*i +: 32] = m_mem[SB + i*SS + 1];
            end
            m_px = m_mem[PLAYER]; m_py = m_mem[PLAYER + 1];
            m_lives = m_mem[LIVES]; m_score = m_mem[SCORE];
            m_laser = {31'b0, hist2[2]};
            m_frame = (m_frame + 32'd1) & FMASK;
         end
         if (wEn && a < DEPTH && a != LEFT && a != RIGHT && a != LASER && a != FRAME)
            m_mem[a] = dataIn;
         hist3 = hist2; hist2 = hist1;
         hist1 = {frameTick, laserOn, moveRight, moveLeft};
      end
      if (chk_en) exp_q.push_back(m_dout);
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      if (chk_en && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("dataOut", TW'(dataOut), TW'(e));
         check("spriteX", spriteX, m_sx);
         check("spriteY", spriteY, m_sy);
         check("playerX", TW'(playerX), TW'(m_px));
         check("playerY", TW'(playerY), TW'(m_py));
         check("lives", TW'(playerLives), TW'(m_lives));
         check("score", TW'(playerScore), TW'(m_score));
         check("laser", TW'(laser), TW'(m_laser));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         wEn = 1'b0; addr = '0; @(negedge clk);
      end
   endtask

   task automatic store(input int a, input logic [31:0] d);
      wEn = 1'b1; addr = 12'(a); dataIn = d; @(negedge clk);
   endtask

   task automatic load(input int a, output logic [31:0] v);
      wEn = 1'b0; addr = 12'(a); @(negedge clk); v = dataOut;
   endtask

   task automatic tick();
      frameTick = 1'b1; idle(1); frameTick = 1'b0; idle(3);
   endtask

   function automatic int pick_addr();
      case ($urandom_range(0, 9))
         0: return LEFT;
         1: return RIGHT;
         2: return LASER;
         3: return FRAME;
         4, 5: return SB + SS * int'($urandom_range(0, NS - 1)) + int'($urandom_range(0, 1));
         6: return PLAYER + int'($urandom_range(0, 1));
         7: return ($urandom_range(0, 1) == 1) ? LIVES : SCORE;
         8: return DEPTH + int'($urandom_range(0, 2047));
         default: return int'($urandom_range(0, DEPTH - 1));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r;
      reset = 1'b1; moveLeft = 1'b1; moveRight = 1'b1; laserOn = 1'b1;
      @(negedge clk); chk_en = 1'b1;
      idle(2);
      check("rst_dout", TW'(dataOut), TW'(32'h0));
      check("rst_spriteX", spriteX, '0);
      check("rst_playerX", TW'(playerX), TW'(32'h0));
      check("rst_laser", TW'(laser), TW'(32'h0));
      reset = 1'b0;
      load(LEFT, r);
      check("sync_flops_reset", TW'(r), TW'(32'h0));
      moveLeft = 1'b0; moveRight = 1'b0; laserOn = 1'b0;
      idle(4);
      load(LEFT, r); load(RIGHT, r); load(LASER, r);
      for (int a = 0; a < DEPTH; a++) store(a, 32'h0);

      // frame snapshot of sprite 0
      store(SB, 32'h55); store(SB + 1, 32'h66);
      tick();
      check("snap_x0", TW'(spriteX[31:0]), TW'(32'h55));
      check("snap_y0", TW'(spriteY[31:0]), TW'(32'h66));
      store(SB, 32'h77); idle(4);
      check("snap_hold", TW'(spriteX[31:0]), TW'(32'h55));
      tick();
      check("snap_next", TW'(spriteX[31:0]), TW'(32'h77));

      // clear-on-read press latch
      moveLeft = 1'b1; idle(1); moveLeft = 1'b0; idle(3);
      load(LEFT, r); check("left_latched", TW'(r), TW'(32'h2));
      load(LEFT, r); check("left_cleared", TW'(r), TW'(32'h0));

      // press edge coinciding with a load: set wins
      moveRight = 1'b1; idle(2);
      load(RIGHT, r); check("right_same_cycle", TW'(r), TW'(32'h1));
      load(RIGHT, r); check("right_set_wins", TW'(r), TW'(32'h3));
      load(RIGHT, r); check("right_cleared", TW'(r), TW'(32'h1));
      moveRight = 1'b0; idle(3);

      // read-only and unmapped stores dropped
      store(0, 32'h1234);
      store(LEFT, 32'hDEAD);
      load(LEFT, r); check("ro_left", TW'(r), TW'(32'h0));
      store(DEPTH, 32'hBEEF);
      load(DEPTH, r); check("unmapped_load", TW'(r), TW'(32'h0));
      load(0, r); check("unmapped_no_alias", TW'(r), TW'(32'h1234));
      load(4095, r); check("unmapped_top", TW'(r), TW'(32'h0));

      // reset mid-operation discards press latch; frame counter wrap
      moveLeft = 1'b1; idle(3);
      reset = 1'b1; idle(2); moveLeft = 1'b0; reset = 1'b0;
      load(LEFT, r); check("rst_sticky_gone", TW'(r), TW'(32'h0));
      load(FRAME, r); check("frame_after_rst", TW'(r), TW'(32'h0));
      for (int i = 0; i < 15; i++) tick();
      load(FRAME, r); check("frame_max", TW'(r), TW'(32'hF));
      tick();
      load(FRAME, r); check("frame_wrap", TW'(r), TW'(32'h0));

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) moveLeft = ~moveLeft;
         if ($urandom_range(0, 7) == 0) moveRight = ~moveRight;
         if ($urandom_range(0, 7) == 0) laserOn = ~laserOn;
         frameTick = ($urandom_range(0, 9) == 0);
         if (i == 700) begin
            reset = 1'b1; idle(2); reset = 1'b0;
         end
         wEn = ($urandom_range(0, 1) == 1);
         addr = 12'(pick_addr());
         dataIn = $urandom;
         @(negedge clk);
      end
      frameTick = 1'b0;
      idle(4);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
